// File: rtl/trace_fifo_arbiter_if.sv
// Producer-side record handshake and FIFO write-port pins shared by the trace arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the taps and FIFO.
interface trace_fifo_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]       in_valid;
  logic [NUM_REQ*WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]       in_ready;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wr_data;
  logic [ID_WIDTH-1:0]      fifo_wr_id;
  logic                     fifo_full;
  logic [ADDR_WIDTH:0]      fifo_count;

  modport master (
    output in_valid, in_data, fifo_full, fifo_count,
    input  in_ready, fifo_wr_en, fifo_wr_data, fifo_wr_id
  );

  modport slave (
    input  in_valid, in_data, fifo_full, fifo_count,
    output in_ready, fifo_wr_en, fifo_wr_data, fifo_wr_id
  );
endinterface

// File: rtl/trace_fifo_arbiter.sv
// Round-robin arbiter that merges NUM_REQ trace taps into one registered FIFO write port.
// It keeps per-tap statistics counters for accepted and dropped records.
module trace_fifo_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int CNT_WIDTH  = 32,
  parameter int LOSSY      = 0,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  trace_fifo_arbiter_if.slave          bus,
  input  logic                         clr_stats,
  output logic [NUM_REQ*CNT_WIDTH-1:0] accept_count,
  output logic [NUM_REQ*CNT_WIDTH-1:0] drop_count
);
  localparam int SW = ADDR_WIDTH + 2;
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] gnt;
  logic [ID_WIDTH:0]   scan_idx;
  logic                slot_ok;
  logic                gnt_vld;
  logic [WIDTH-1:0]    gnt_data;
  logic [NUM_REQ-1:0]  gnt_onehot;

  // The registered write is not yet visible in fifo_count, so it is counted here.
  assign slot_ok = !bus.fifo_full &&
                   (({1'b0, bus.fifo_count} + SW'(bus.fifo_wr_en)) < SW'(FIFO_DEPTH));

  assign gnt_vld = (|bus.in_valid) && slot_ok;

  // The scan runs downward, so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    gnt      = rr_ptr;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
      if (scan_idx >= (ID_WIDTH+1)'(NUM_REQ))
        scan_idx = scan_idx - (ID_WIDTH+1)'(NUM_REQ);
      if (bus.in_valid[scan_idx[ID_WIDTH-1:0]])
        gnt = scan_idx[ID_WIDTH-1:0];
    end
  end

  always_comb begin
    gnt_data   = '0;
    gnt_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == ID_WIDTH'(i)) begin
        gnt_data      = bus.in_data[i*WIDTH +: WIDTH];
        gnt_onehot[i] = gnt_vld;
      end
    end
  end

  assign bus.in_ready = (LOSSY != 0) ? {NUM_REQ{1'b1}} : (rst_n ? gnt_onehot : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fifo_wr_en   <= 1'b0;
      bus.fifo_wr_data <= '0;
      bus.fifo_wr_id   <= '0;
      rr_ptr           <= '0;
    end else begin
      bus.fifo_wr_en <= gnt_vld;
      if (gnt_vld) begin
        bus.fifo_wr_data <= gnt_data;
        bus.fifo_wr_id   <= gnt;
        rr_ptr           <= (gnt == LAST_ID) ? '0 : gnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0] drop_q;
    logic                 acc_inc;
    logic                 drop_inc;

    assign acc_inc  = gnt_onehot[i];
    assign drop_inc = (LOSSY != 0) && bus.in_valid[i] && !gnt_onehot[i];

    // Counters saturate. A clear in the same cycle as an increment discards the increment.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q  <= '0;
        drop_q <= '0;
      end else if (clr_stats) begin
        acc_q  <= '0;
        drop_q <= '0;
      end else begin
        if (acc_inc && (acc_q != '1))
          acc_q <= acc_q + 1'b1;
        if (drop_inc && (drop_q != '1))
          drop_q <= drop_q + 1'b1;
      end
    end

    assign accept_count[i*CNT_WIDTH +: CNT_WIDTH] = acc_q;
    assign drop_count[i*CNT_WIDTH +: CNT_WIDTH]   = drop_q;
  end
endmodule

// File: tb/tb_trace_fifo_arbiter.sv
// Bench that runs a lossless and a lossy (narrow-counter) arbiter in lockstep on shared stimulus.
// Both are checked against a queue-free behavioural model of grant order, write port and statistics.
module tb_trace_fifo_arbiter;
  localparam int NR   = 4;
  localparam int W    = 64;
  localparam int D    = 16;
  localparam int AW   = 4;
  localparam int IW   = 2;
  localparam int CW_A = 32;
  localparam int CW_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]   valid;
  logic [NR*W-1:0] data_v;
  logic            rd;
  logic            clr;
  logic            preset_en;
  int              preset_val;
  int              cnt_q [2] = '{0, 0};

  logic [NR*CW_A-1:0] acc_a, drp_a;
  logic [NR*CW_B-1:0] acc_b, drp_b;

  trace_fifo_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus_a ();
  trace_fifo_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus_b ();

  assign bus_a.in_valid   = valid;
  assign bus_a.in_data    = data_v;
  assign bus_a.fifo_count = (AW+1)'(cnt_q[0]);
  assign bus_a.fifo_full  = (cnt_q[0] >= D);
  assign bus_b.in_valid   = valid;
  assign bus_b.in_data    = data_v;
  assign bus_b.fifo_count = (AW+1)'(cnt_q[1]);
  assign bus_b.fifo_full  = (cnt_q[1] >= D);

  trace_fifo_arbiter #(.NUM_REQ(NR), .WIDTH(W), .FIFO_DEPTH(D), .CNT_WIDTH(CW_A), .LOSSY(0)) u_ll (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .clr_stats(clr),
    .accept_count(acc_a), .drop_count(drp_a));

  trace_fifo_arbiter #(.NUM_REQ(NR), .WIDTH(W), .FIFO_DEPTH(D), .CNT_WIDTH(CW_B), .LOSSY(1)) u_ly (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .clr_stats(clr),
    .accept_count(acc_b), .drop_count(drp_b));

  // Environment FIFO occupancy (not reset with the arbiter).
  always @(posedge clk) begin
    if (preset_en) begin
      cnt_q[0] <= preset_val;
      cnt_q[1] <= preset_val;
    end else begin
      cnt_q[0] <= cnt_q[0] + int'(bus_a.fifo_wr_en) - ((rd && cnt_q[0] > 0) ? 1 : 0);
      cnt_q[1] <= cnt_q[1] + int'(bus_b.fifo_wr_en) - ((rd && cnt_q[1] > 0) ? 1 : 0);
    end
  end

  int          comps = 0;
  int          fails = 0;
  int          ptr   [2];
  bit          ewr   [2];
  logic [63:0] edata [2];
  int          eid   [2];
  longint      eacc  [2][NR];
  longint      edrp  [2][NR];
  logic [NR-1:0] last_acc;

  function automatic logic [63:0] acc_of(input int m, input int i);
    return (m == 0) ? 64'(acc_a[i*CW_A +: CW_A]) : 64'(acc_b[i*CW_B +: CW_B]);
  endfunction

  function automatic logic [63:0] drp_of(input int m, input int i);
    return (m == 0) ? 64'(drp_a[i*CW_A +: CW_A]) : 64'(drp_b[i*CW_B +: CW_B]);
  endfunction

  function automatic logic [NR-1:0] rdy_of(input int m);
    return (m == 0) ? bus_a.in_ready : bus_b.in_ready;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    comps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ptr[m] = 0; ewr[m] = 1'b0; edata[m] = '0; eid[m] = 0;
      for (int i = 0; i < NR; i++) begin eacc[m][i] = 0; edrp[m][i] = 0; end
    end
    last_acc = '0;
  endtask

  task automatic check_outputs();
    chk("wr_en_ll", 64'(bus_a.fifo_wr_en), 64'(ewr[0]));
    chk("wr_data_ll", bus_a.fifo_wr_data, edata[0]);
    chk("wr_id_ll", 64'(bus_a.fifo_wr_id), 64'(eid[0]));
    chk("wr_en_ly", 64'(bus_b.fifo_wr_en), 64'(ewr[1]));
    chk("wr_data_ly", bus_b.fifo_wr_data, edata[1]);
    chk("wr_id_ly", 64'(bus_b.fifo_wr_id), 64'(eid[1]));
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NR; i++) begin
        chk($sformatf("accept[%0d][%0d]", m, i), acc_of(m, i), 64'(eacc[m][i]));
        chk($sformatf("drop[%0d][%0d]", m, i), drp_of(m, i), 64'(edrp[m][i]));
      end
  endtask

  // One clock of stimulus: predict handshake, cross the edge, update model, compare.
  task automatic cycle();
    int      win [2];
    bit      gv  [2];
    longint  sat;
    logic [NR-1:0] er;
    #1;
    for (int m = 0; m < 2; m++) begin
      bit slot;
      slot = (cnt_q[m] < D) && ((cnt_q[m] + int'(ewr[m])) < D);
      win[m] = -1;
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (ptr[m] + k) % NR;
        if (win[m] < 0 && valid[j]) win[m] = j;
      end
      gv[m] = slot && (win[m] >= 0);
      er = '0;
      if (m == 1) er = '1;
      else if (gv[m]) er[win[m]] = 1'b1;
      chk($sformatf("in_ready[%0d]", m), 64'(rdy_of(m)), 64'(er));
      chk($sformatf("fifo_bound[%0d]", m), 64'(cnt_q[m] <= D), 64'd1);
    end
    last_acc = '0;
    if (gv[0]) last_acc[win[0]] = 1'b1;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      sat = (longint'(1) << ((m == 0) ? CW_A : CW_B)) - 1;
      if (clr) begin
        for (int i = 0; i < NR; i++) begin eacc[m][i] = 0; edrp[m][i] = 0; end
      end else begin
        if (gv[m] && eacc[m][win[m]] < sat) eacc[m][win[m]]++;
        if (m == 1)
          for (int i = 0; i < NR; i++)
            if (valid[i] && !(gv[m] && win[m] == i) && edrp[m][i] < sat) edrp[m][i]++;
      end
      ewr[m] = gv[m];
      if (gv[m]) begin
        edata[m] = data_v[win[m]*W +: W];
        eid[m]   = win[m];
        ptr[m]   = (win[m] + 1) % NR;
      end
    end
    check_outputs();
    for (int i = 0; i < NR; i++)
      if (!(valid[i] && !last_acc[i])) data_v[i*W +: W] = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    valid = '0; rd = 1'b0; clr = 1'b0; preset_en = 1'b0; preset_val = 0;
    for (int i = 0; i < NR; i++) data_v[i*W +: W] = {$urandom, $urandom};
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy_ll", 64'(bus_a.in_ready), 64'h0);
    chk("reset_rdy_ly", 64'(bus_b.in_ready), 64'hF);
    check_outputs();
    rst_n = 1'b1;

    // All four valid, FIFO empty: grants 0,1,2,3,0,1,2,3.
    valid = 4'b1111;
    repeat (8) cycle();
    for (int i = 0; i < NR; i++) chk("t1_accept", acc_of(0, i), 64'd2);

    // Pre-fill to 14: only two writes fit (req0 then req2).
    valid = '0;
    cycle();
    preset_en = 1'b1; preset_val = 14;
    cycle();
    preset_en = 1'b0;
    valid = 4'b0101;
    repeat (4) cycle();
    chk("t2_count", 64'(cnt_q[0]), 64'd16);
    chk("t2_acc0", acc_of(0, 0), 64'd3);
    chk("t2_acc2", acc_of(0, 2), 64'd3);

    // Drain, park rr_ptr at 0 via a grant to req3, then req3 alone for 5 cycles.
    valid = '0; rd = 1'b1;
    repeat (17) cycle();
    rd = 1'b0;
    valid = 4'b1000;
    cycle();
    repeat (5) cycle();
    chk("t3_acc3", acc_of(0, 3), 64'd8);
    chk("t3_id", 64'(bus_a.fifo_wr_id), 64'd3);

    // Lossy with FIFO full: drops only.
    valid = '0;
    preset_en = 1'b1; preset_val = 16;
    cycle();
    preset_en = 1'b0;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    valid = 4'b1111;
    repeat (4) cycle();
    for (int i = 0; i < NR; i++) chk("t4_drop", drp_of(1, i), 64'd4);
    chk("t4_drop_ll", drp_of(0, 1), 64'd0);

    // Clear coincident with drops, then resume and saturate at 7.
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("t5_clr_drop", drp_of(1, 2), 64'd0);
    cycle();
    chk("t5_resume", drp_of(1, 2), 64'd1);
    repeat (8) cycle();
    chk("t5_saturate", drp_of(1, 0), 64'd7);

    // Randomized traffic with held lossless producers, random reads and occasional clears.
    valid = '0;
    preset_en = 1'b1; preset_val = 0;
    cycle();
    preset_en = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++)
        if (!(valid[i] && !last_acc[i])) valid[i] = 1'($urandom_range(0, 1));
      rd  = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 49) == 0);
      cycle();
    end
    clr = 1'b0;

    // Reset mid-burst cancels the in-flight write; first grant afterwards is lowest valid index.
    valid = '0; rd = 1'b0;
    preset_en = 1'b1; preset_val = 0;
    cycle();
    preset_en = 1'b0;
    valid = 4'b1111; rd = 1'b1;
    repeat (3) cycle();
    chk("t6_burst_wr_en", 64'(bus_a.fifo_wr_en), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_rdy_ll", 64'(bus_a.in_ready), 64'h0);
    chk("t6_rst_rdy_ly", 64'(bus_b.in_ready), 64'hF);
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid = 4'b1010;
    cycle();
    chk("t6_first_id", 64'(bus_a.fifo_wr_id), 64'd1);
    chk("t6_first_en", 64'(bus_a.fifo_wr_en), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end
endmodule

// File: doc/trace_fifo_arbiter.md
Name: trace_fifo_arbiter

Overview:
- Shares one sync FIFO write port among NUM_REQ trace-record producers (e.g. per-stage latency taps).
- Round-robin arbitration; one record per cycle into the FIFO; registered write stage.
- Lossless mode: back-pressures producers. Lossy mode: producers are never stalled and un-granted records are counted as drops.
- Sits between the trace taps and the FIFO's wr_en/wr_data/full/count pins.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 64, record width; matches FIFO WIDTH
FIFO_DEPTH, 16, depth of the attached FIFO
ADDR_WIDTH, $clog2(FIFO_DEPTH), FIFO address width; the count port is ADDR_WIDTH+1 bits
CNT_WIDTH, 32, width of each statistics counter
LOSSY, 0, 0 = back-pressure producers; 1 = in_ready tied high, count drops
ID_WIDTH, $clog2(NUM_REQ), grant id width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  NUM_REQ  per-requester record valid
in_data  in  NUM_REQ*WIDTH  packed records; requester i uses bits [i*WIDTH +: WIDTH]
in_ready  out  NUM_REQ  per-requester accept
fifo_wr_en  out  1  registered FIFO write enable
fifo_wr_data  out  WIDTH  registered FIFO write data
fifo_wr_id  out  ID_WIDTH  requester id of the current fifo_wr_data
fifo_full  in  1  FIFO full flag
fifo_count  in  ADDR_WIDTH+1  FIFO fill count
clr_stats  in  1  synchronous clear of all counters
accept_count  out  NUM_REQ*CNT_WIDTH  per-requester records written
drop_count  out  NUM_REQ*CNT_WIDTH  per-requester records dropped (LOSSY=1 only; 0 otherwise)

Behaviour:
- Reset values (asynchronous, rst_n low): fifo_wr_en=0, fifo_wr_data=0, fifo_wr_id=0, rr_ptr=0, all counters=0. in_ready is combinational; it is 0 while in reset when LOSSY=0.
- Slot availability:
  - slot_ok = !fifo_full && (fifo_count + fifo_wr_en) < FIFO_DEPTH.
  - The in-flight registered write is not yet reflected in fifo_count, so it is added explicitly.
  - FIFO reads only free space, so the rule is conservative; the FIFO can never be written while full.
- Arbitration (combinational, each cycle):
  - Scan requesters rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - The first with in_valid=1 is the winner gnt; gnt_vld = any in_valid && slot_ok.
- Handshake:
  - LOSSLESS (LOSSY=0): in_ready[i] = gnt_vld && gnt==i. Producers hold in_valid and in_data until in_ready is seen. in_ready never depends on in_valid of the same requester except through arbitration.
  - LOSSY (LOSSY=1): in_ready = all ones. Each i with in_valid[i] && !(gnt_vld && gnt==i) increments drop_count[i] by 1.
- Write stage (registered), on each clk edge:
  - fifo_wr_en <= gnt_vld.
  - If gnt_vld: fifo_wr_data <= in_data[gnt], fifo_wr_id <= gnt.
  - When gnt_vld=0, data and id hold their previous values.
- Latency: accepted record appears on the FIFO port exactly 1 cycle after its in_ready/in_valid handshake. Throughput is 1 record/cycle while slot_ok holds.
- Round-robin pointer:
  - On gnt_vld, rr_ptr <= (gnt==NUM_REQ-1) ? 0 : gnt+1. Otherwise rr_ptr holds.
  - Fairness: with all requesters continuously valid and space available, each is granted exactly once per NUM_REQ consecutive grants.
- Counters:
  - accept_count[gnt] increments by 1 on each gnt_vld.
  - All counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - clr_stats=1 zeroes all counters at the next edge; an increment in the same cycle is discarded (clear wins).
- Boundary conditions:
  - FIFO reaches FIFO_DEPTH-1 with a write in flight: slot_ok=0, no grant, no in_ready.
  - Simultaneous FIFO read: the freed space is used the following cycle (from the updated fifo_count).
  - Single valid requester: granted every cycle space allows, regardless of rr_ptr.
  - No valid inputs: fifo_wr_en=0 next cycle, rr_ptr unchanged.
  - Reset asserted mid-stream: the in-flight write is cancelled (fifo_wr_en=0 immediately); records not yet accepted remain the producer's responsibility.

Test Plan:
1. NUM_REQ=4, all in_valid=1 for 8 cycles, FIFO empty and not read -> grants 0,1,2,3,0,1,2,3; fifo_wr_id follows one cycle later; accept_count = 2 each.
2. FIFO pre-filled to 14, no reads, req0 and req2 valid -> exactly 2 writes (req0 then req2), then in_ready=0 and fifo_wr_en=0; FIFO count is 16 and never exceeds it.
3. Only req3 valid for 5 cycles with rr_ptr=0 -> 5 consecutive grants to req3, fifo_wr_data equals each in_data[3] one cycle later.
4. LOSSY=1, all 4 valid for 4 cycles with FIFO full -> no writes; drop_count = 4 each; in_ready stays all-ones.
5. LOSSY=1, clr_stats pulsed in the same cycle as a drop -> all counters read 0 next cycle; counting resumes the cycle after.
6. rst_n asserted during a burst with fifo_wr_en=1 -> fifo_wr_en=0 and rr_ptr=0 asynchronously. After release, the first grant goes to the lowest-index valid requester.
